// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: prefetch FIFO, instruction register and timestep FSM.
// Optional FETCH_PERF_CNT_EN adds saturating retired-instruction and stall-cycle counters.
module instr_fetch_sequencer #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4,
   parameter int TSW   = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             IRin,
   input  logic             Ext,
   input  logic             Clr,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] IR,
   output logic [TSW-1:0]   timestep,
   output logic             stall,
   output logic [15:0]      instr_count,
   output logic [15:0]      stall_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [TSW-1:0] {
      TS0 = TSW'(0),
      TS1 = TSW'(1),
      TS2 = TSW'(2),
      TS3 = TSW'(3)
   } ts_e;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   ts_e              ts_q, ts_d;

   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             ir_load;
   logic [WIDTH-1:0] head;

   // A stalled step is simply Ext with nothing to pop, so it never pops or loads IR.
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == CW'(DEPTH));
      in_ready = reset_n & ~full;
      push     = in_valid & in_ready;
      pop      = Ext & ~empty;
      ir_load  = IRin & ~empty;
      stall    = Ext & empty;
      head     = mem_q[rd_ptr_q];
      data_out = pop ? head : '0;

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end

      ir_d = ir_load ? head : ir_q;

      ts_d = ts_q;
      if (stall) begin
         ts_d = ts_q;
      end else if (Clr) begin
         ts_d = TS0;
      end else begin
         ts_d = ts_e'(ts_q + TSW'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ir_q     <= '0;
         ts_q     <= TS0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ir_q     <= ir_d;
         ts_q     <= ts_d;
      end
   end

   // Storage needs no reset: the flushed count makes stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign IR       = ir_q;
   assign timestep = ts_q;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] instr_count_q, instr_count_d;
   logic [15:0] stall_count_q, stall_count_d;

   always_comb begin
      instr_count_d = instr_count_q;
      stall_count_d = stall_count_q;
      if (ir_load && instr_count_q != 16'hFFFF) begin
         instr_count_d = instr_count_q + 16'd1;
      end
      if (stall && stall_count_q != 16'hFFFF) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         instr_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         instr_count_q <= instr_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign instr_count = instr_count_q;
   assign stall_count = stall_count_q;
`else
   assign instr_count = 16'd0;
   assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: a queue scoreboard holds the words the
// FIFO should contain and the bench's own model tracks IR, timestep and perf counters.
module tb_instr_fetch_sequencer;

   localparam int WIDTH = 10;
   localparam int DEPTH = 4;
   localparam int TSW   = 2;

   logic             clk;
   logic             reset_n;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             IRin;
   logic             Ext;
   logic             Clr;
   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] IR;
   logic [TSW-1:0]   timestep;
   logic             stall;
   logic [15:0]      instr_count;
   logic [15:0]      stall_count;

   instr_fetch_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TSW(TSW)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .IRin(IRin),
      .Ext(Ext),
      .Clr(Clr),
      .data_out(data_out),
      .IR(IR),
      .timestep(timestep),
      .stall(stall),
      .instr_count(instr_count),
      .stall_count(stall_count)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checkCount = 0;
   int passCount  = 0;

   logic [WIDTH-1:0] sbQ[$];
   logic [WIDTH-1:0] mIr;
   int               mTs;
   int               mInstr;
   int               mStalls;

   // Single comparison point: counts every check and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   function automatic logic [15:0] expInstr();
`ifdef FETCH_PERF_CNT_EN
      return 16'(mInstr);
`else
      return 16'd0;
`endif
   endfunction

   function automatic logic [15:0] expStalls();
`ifdef FETCH_PERF_CNT_EN
      return 16'(mStalls);
`else
      return 16'd0;
`endif
   endfunction

   task automatic checkRegs(input string tag);
      checkOutput({tag, "_ir"}, 32'(IR), 32'(mIr));
      checkOutput({tag, "_ts"}, 32'(timestep), 32'(mTs));
      checkOutput({tag, "_icnt"}, 32'(instr_count), 32'(expInstr()));
      checkOutput({tag, "_scnt"}, 32'(stall_count), 32'(expStalls()));
   endtask

   // Reset for one edge; in_ready must be low during it and the FIFO must come back empty.
   task automatic doReset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      IRin     = 1'b0;
      Ext      = 1'b0;
      Clr      = 1'b0;
      #4;
      checkOutput("rst_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      sbQ.delete();
      mIr     = '0;
      mTs     = 0;
      mInstr  = 0;
      mStalls = 0;
      checkRegs("rst");
      Ext = 1'b1;
      #2;
      checkOutput("rst_in_ready_high", 32'(in_ready), 32'd1);
      checkOutput("rst_data_out", 32'(data_out), 32'd0);
      checkOutput("rst_flushed_stall", 32'(stall), 32'd1);
      Ext = 1'b0;
   endtask

   // One clock step: drive, check combinational outputs against the scoreboard, advance the model, check registers.
   task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data,
                                input logic irin, input logic ext, input logic clr);
      bit               mEmpty;
      bit               mReady;
      logic [WIDTH-1:0] expData;
      in_valid = valid;
      in_data  = data;
      IRin     = irin;
      Ext      = ext;
      Clr      = clr;
      #4;
      mEmpty  = (sbQ.size() == 0);
      mReady  = (sbQ.size() < DEPTH);
      expData = (ext && !mEmpty) ? sbQ[0] : '0;
      checkOutput("in_ready", 32'(in_ready), 32'(mReady));
      checkOutput("stall", 32'(stall), 32'(ext && mEmpty));
      checkOutput("data_out", 32'(data_out), 32'(expData));

      if (irin && !mEmpty) begin
         mIr = sbQ[0];
         if (mInstr < 16'hFFFF) mInstr++;
      end
      if (ext && mEmpty) begin
         if (mStalls < 16'hFFFF) mStalls++;
      end else if (clr) begin
         mTs = 0;
      end else begin
         mTs = (mTs + 1) % (1 << TSW);
      end
      if (ext && !mEmpty) void'(sbQ.pop_front());
      if (valid && mReady) sbQ.push_back(data);

      @(posedge clk);
      #1;
      checkRegs("step");
   endtask

   initial begin
      doReset();

      // Fetch COPY at TS0: push while holding TS0 with Clr, then IRin+Ext.
      applyStimulus(1'b1, 10'h004, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 1'b0);
      checkOutput("fetch_ir", 32'(IR), 32'h004);
      checkOutput("fetch_ts", 32'(timestep), 32'd1);

      // Operand missing at TS1: stall three cycles, push arrives, then one step.
      repeat (3) applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
      checkOutput("stall_ts_held", 32'(timestep), 32'd1);
      applyStimulus(1'b1, 10'h155, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
      checkOutput("stall_release_ts", 32'(timestep), 32'd2);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 1'b1);

      // Full: five pushes without pops, fifth rejected; one pop reopens, then drain.
      for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 10'(10'h100 + i), 1'b0, 1'b0, 1'b1);
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
      checkOutput("full_reopen", 32'(in_ready), 32'd1);
      // Simultaneous push and pop keeps order.
      applyStimulus(1'b1, 10'h2AA, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 10'h2BB, 1'b0, 1'b1, 1'b1);
      repeat (4) applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);

      // ALU sequence with Clr at TS3, then a natural wrap, then Clr at TS0 with IR reload.
      applyStimulus(1'b1, 10'h011, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
      checkOutput("alu_ts3", 32'(timestep), 32'd3);
      applyStimulus(1'b1, 10'h022, 1'b0, 1'b0, 1'b1);
      checkOutput("alu_clr_ts3", 32'(timestep), 32'd0);
      applyStimulus(1'b1, 10'h033, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
      checkOutput("alu_wrap", 32'(timestep), 32'd0);
      applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 1'b1);
      checkOutput("clr_ts0_ir", 32'(IR), 32'h033);
      checkOutput("clr_ts0_ts", 32'(timestep), 32'd0);

      // Mid-stream reset drops buffered words and the held instruction.
      applyStimulus(1'b1, 10'h3C3, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 10'h0F0, 1'b1, 1'b0, 1'b0);
      doReset();
      checkOutput("midrst_ir", 32'(IR), 32'd0);

      // Perf: three instruction loads and two stall cycles from reset.
      applyStimulus(1'b1, 10'h041, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 10'h042, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 10'h043, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("perf_instr", 32'(instr_count), 32'd3);
      checkOutput("perf_stall", 32'(stall_count), 32'd2);
`else
      checkOutput("perf_instr_off", 32'(instr_count), 32'd0);
      checkOutput("perf_stall_off", 32'(stall_count), 32'd0);
`endif
      checkOutput("perf_ir", 32'(IR), 32'h043);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
